cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 33 +++
 rtl/cdb_arbiter.sv | 108 ++++++++++
 tb/tb_cdb_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: FU completion side plus broadcast side.
// master = arbiter, slave = FUs / CDB consumer.
interface cdb_arbiter_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 7,
  parameter int NUM_FU      = 4,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [NUM_FU-1:0]            done;
  logic [NUM_FU*TAG_WIDTH-1:0]  tag_in;
  logic [NUM_FU*DATA_WIDTH-1:0] data_in;
  logic [NUM_FU-1:0]            queued;
  logic                         cdb_valid;
  logic [TAG_WIDTH-1:0]         cdb_tag;
  logic [DATA_WIDTH-1:0]        cdb_data;
  logic                         cdb_ready;
  logic [CW-1:0]                count;
  logic                         full;

  modport master (
    input  done, tag_in, data_in, cdb_ready,
    output queued, cdb_valid, cdb_tag, cdb_data,
    output count, full
  );

  modport slave (
    output done, tag_in, data_in, cdb_ready,
    input  queued, cdb_valid, cdb_tag, cdb_data,
    input  count, full
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter feeding a circular broadcast FIFO.
// Ports: clk, rst (async active-low), bus (cdb_arbiter_if.master).
module cdb_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 7,
  parameter int NUM_FU      = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.master bus
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(NUM_FU);
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } cdb_ent_t;

  logic [NUM_FU-1:0] pending;
  logic [NUM_FU-1:0] grant;
  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     grant_idx;
  logic [IW-1:0]     cand;
  logic              found;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic              valid;
  cdb_ent_t          sel;
  cdb_ent_t          mem [QUEUE_DEPTH];

  // Search starts one past the last winner and wraps.
  // A full queue blocks grants even if it pops this cycle.
  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    cand      = '0;
    if (count < DEPTH_C) begin
      for (int k = 1; k <= NUM_FU; k++) begin
        cand = IW'((int'(last_grant) + k) % NUM_FU);
        if (!found && pending[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        sel.tag  = bus.tag_in[i*TAG_WIDTH +: TAG_WIDTH];
        sel.data = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign valid = (count != '0);
  assign push  = |grant;
  assign pop   = valid & bus.cdb_ready;

  // A done pulse on an already pending FU is absorbed;
  // the grant clears the bit even if done fires again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= '0;
      last_grant <= IW'(NUM_FU - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      pending <= (pending & ~grant) | (bus.done & ~pending);
      if (push) begin
        last_grant <= grant_idx;
        wr_ptr     <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: reads are gated by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sel;
  end

  assign bus.queued    = grant;
  assign bus.cdb_valid = valid;
  assign bus.cdb_tag   = valid ? mem[rd_ptr].tag  : '0;
  assign bus.cdb_data  = valid ? mem[rd_ptr].data : '0;
  assign bus.count     = count;
  assign bus.full      = (count == DEPTH_C);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a broadcast scoreboard.
// Expected entries are queued at stimulus, popped on cdb handshakes.
module tb_cdb_arbiter;

  localparam int DW = 32;
  localparam int TW = 7;
  localparam int NF = 4;
  localparam int QD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .NUM_FU(NF), .QUEUE_DEPTH(QD)
  ) bus ();

  cdb_arbiter #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .NUM_FU(NF), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int total = 0;
  int bad   = 0;
  logic [TW+DW-1:0] sb[$];
  int ord[4] = '{1, 2, 3, 0};

  task automatic chk(string name, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             name, obs, exp);
    end
  endtask

  task automatic set_fu(int i, logic [TW-1:0] t,
                        logic [DW-1:0] d);
    bus.tag_in[i*TW +: TW]  = t;
    bus.data_in[i*DW +: DW] = d;
  endtask

  task automatic push_exp(int i);
    logic [TW+DW-1:0] e;
    e = {bus.tag_in[i*TW +: TW], bus.data_in[i*DW +: DW]};
    sb.push_back(e);
  endtask

  task automatic tick();
    logic [TW+DW-1:0] e;
    if (bus.cdb_valid && bus.cdb_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_empty observed tag=%0h expected none",
               bus.cdb_tag);
      end else begin
        e = sb.pop_front();
        chk("cdb_tag", 64'(bus.cdb_tag), 64'(e[TW+DW-1:DW]));
        chk("cdb_data", 64'(bus.cdb_data), 64'(e[DW-1:0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.cdb_ready = 1'b1;
    for (int n = 0; n < 20 && bus.count != '0; n++) tick();
    chk("drain_count", 64'(bus.count), 64'(0));
    chk("sb_left", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    bus.done      = '0;
    bus.tag_in    = '0;
    bus.data_in   = '0;
    bus.cdb_ready = 1'b0;
    tick();
    tick();
    chk("rst_queued", 64'(bus.queued), 64'(0));
    chk("rst_valid", 64'(bus.cdb_valid), 64'(0));
    chk("rst_tag", 64'(bus.cdb_tag), 64'(0));
    chk("rst_data", 64'(bus.cdb_data), 64'(0));
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_full", 64'(bus.full), 64'(0));
    rst = 1'b1;
    tick();
    chk("rel_queued", 64'(bus.queued), 64'(0));
    chk("rel_valid", 64'(bus.cdb_valid), 64'(0));
    chk("rel_count", 64'(bus.count), 64'(0));

    // all four at once after reset: FU0 first
    for (int i = 0; i < NF; i++)
      set_fu(i, TW'(8'h20 + i), DW'(32'h100 + i));
    bus.cdb_ready = 1'b1;
    bus.done = 4'b1111;
    for (int i = 0; i < NF; i++) push_exp(i);
    tick();
    bus.done = '0;
    for (int i = 0; i < NF; i++) begin
      chk("rr_all", 64'(bus.queued), 64'(1) << i);
      tick();
    end
    chk("rr_all_idle", 64'(bus.queued), 64'(0));
    drain();

    // single result latency
    set_fu(1, 7'd5, 32'h10);
    bus.done = 4'b0010;
    push_exp(1);
    tick();
    bus.done = '0;
    chk("one_queued", 64'(bus.queued), 64'(4'b0010));
    tick();
    chk("one_qdrop", 64'(bus.queued), 64'(0));
    chk("one_valid", 64'(bus.cdb_valid), 64'(1));
    chk("one_tag", 64'(bus.cdb_tag), 64'(5));
    chk("one_data", 64'(bus.cdb_data), 64'(32'h10));
    tick();
    chk("one_count", 64'(bus.count), 64'(0));
    chk("one_vdrop", 64'(bus.cdb_valid), 64'(0));
    tick();
    chk("rdy_empty_cnt", 64'(bus.count), 64'(0));
    chk("rdy_empty_tag", 64'(bus.cdb_tag), 64'(0));

    // fairness: last grant FU2, then {0,3} -> 3 then 0
    bus.done = 4'b0100;
    push_exp(2);
    tick();
    bus.done = '0;
    chk("fair_fu2", 64'(bus.queued), 64'(4'b0100));
    tick();
    tick();
    bus.done = 4'b1001;
    push_exp(3);
    push_exp(0);
    tick();
    bus.done = '0;
    chk("fair_first", 64'(bus.queued), 64'(4'b1000));
    tick();
    chk("fair_second", 64'(bus.queued), 64'(4'b0001));
    tick();
    chk("fair_idle", 64'(bus.queued), 64'(0));
    drain();

    // full boundary, last grant is FU0
    bus.cdb_ready = 1'b0;
    bus.done = 4'b1111;
    for (int i = 0; i < 4; i++) push_exp(ord[i]);
    tick();
    bus.done = '0;
    for (int i = 0; i < 4; i++) begin
      chk("full_fill", 64'(bus.queued), 64'(1) << ord[i]);
      tick();
    end
    chk("full_flag", 64'(bus.full), 64'(1));
    chk("full_count", 64'(bus.count), 64'(4));
    chk("full_noq", 64'(bus.queued), 64'(0));
    set_fu(0, 7'h40, 32'hAAAA);
    bus.done = 4'b0001;
    tick();
    bus.done = '0;
    chk("full_block1", 64'(bus.queued), 64'(0));
    tick();
    chk("full_block2", 64'(bus.queued), 64'(0));
    chk("full_hold", 64'(bus.count), 64'(4));
    bus.cdb_ready = 1'b1;
    chk("full_popnog", 64'(bus.queued), 64'(0));
    tick();
    bus.cdb_ready = 1'b0;
    chk("full_cnt3", 64'(bus.count), 64'(3));
    chk("full_regrant", 64'(bus.queued), 64'(4'b0001));
    push_exp(0);
    tick();
    chk("full_cnt4", 64'(bus.count), 64'(4));
    chk("full_again", 64'(bus.full), 64'(1));
    drain();

    // reset mid-operation, last grant is FU0
    bus.cdb_ready = 1'b0;
    bus.done = 4'b1011;
    push_exp(1);
    push_exp(3);
    push_exp(0);
    tick();
    bus.done = '0;
    chk("mid_q1", 64'(bus.queued), 64'(4'b0010));
    tick();
    chk("mid_q3", 64'(bus.queued), 64'(4'b1000));
    tick();
    chk("mid_q0", 64'(bus.queued), 64'(4'b0001));
    tick();
    chk("mid_cnt3", 64'(bus.count), 64'(3));
    bus.done = 4'b0100;
    tick();
    bus.done = '0;
    chk("mid_pend2", 64'(bus.queued), 64'(4'b0100));
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.cdb_valid), 64'(0));
    chk("arst_count", 64'(bus.count), 64'(0));
    chk("arst_queued", 64'(bus.queued), 64'(0));
    chk("arst_full", 64'(bus.full), 64'(0));
    chk("arst_tag", 64'(bus.cdb_tag), 64'(0));
    sb.delete();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_noq", 64'(bus.queued), 64'(0));
      chk("post_novalid", 64'(bus.cdb_valid), 64'(0));
      tick();
    end

    // resumes without help; FU2 alone after reset
    bus.cdb_ready = 1'b1;
    bus.done = 4'b0100;
    push_exp(2);
    tick();
    bus.done = '0;
    chk("resume_q", 64'(bus.queued), 64'(4'b0100));
    tick();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
